// File: rtl/ysyx_25030081_cu_pkg.sv
// rtl/ysyx_25030081_cu_pkg.sv - shared codes and control bundle for the multi-cycle control unit
package ysyx_25030081_cu_pkg;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd6;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_SLL    = 4'd2;
   localparam logic [3:0] ALU_SLT    = 4'd3;
   localparam logic [3:0] ALU_SLTU   = 4'd4;
   localparam logic [3:0] ALU_XOR    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_OR     = 4'd8;
   localparam logic [3:0] ALU_AND    = 4'd9;
   localparam logic [3:0] ALU_COPY_B = 4'd10;

   localparam logic [2:0] EXT_I = 3'd0;
   localparam logic [2:0] EXT_S = 3'd1;
   localparam logic [2:0] EXT_B = 3'd2;
   localparam logic [2:0] EXT_U = 3'd3;
   localparam logic [2:0] EXT_J = 3'd4;

   localparam logic [3:0] BR_NONE = 4'd0;
   localparam logic [3:0] BR_JAL  = 4'd1;
   localparam logic [3:0] BR_JALR = 4'd2;
   localparam logic       BR_COND = 1'b1;

   localparam logic       ALU_SRC_RS1 = 1'b0;
   localparam logic       ALU_SRC_PC  = 1'b1;
   localparam logic [1:0] B_SRC_RS2   = 2'd0;
   localparam logic [1:0] B_SRC_IMM   = 2'd1;
   localparam logic [1:0] B_SRC_FOUR  = 2'd2;

   typedef struct packed {
      logic [2:0] ext_op;
      logic       alu_a_src;
      logic [1:0] alu_b_src;
      logic [3:0] alu_op;
      logic [3:0] branch;
      logic       mem_to_reg;
      logic       rd_wr;
      logic       is_load;
      logic       is_store;
      logic [2:0] lsu_op;
   } ctl_t;

   // alt selects SUB for funct3 000 and SRA for funct3 101
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? ALU_SUB : ALU_ADD;
         3'b001:  return ALU_SLL;
         3'b010:  return ALU_SLT;
         3'b011:  return ALU_SLTU;
         3'b100:  return ALU_XOR;
         3'b101:  return alt ? ALU_SRA : ALU_SRL;
         3'b110:  return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_25030081_idu_dec.sv
// rtl/ysyx_25030081_idu_dec.sv - combinational RV32I/RV32E decoder, IR to control bundle
module ysyx_25030081_idu_dec
   import ysyx_25030081_cu_pkg::*;
#(
   parameter bit RVE       = 1'b0,
   parameter bit EN_EBREAK = 1'b1
) (
   input  logic [31:0] ir,
   output ctl_t        ctl,
   output logic        illegal,
   output logic        ebreak
);

   logic [6:0] opcode;
   logic [2:0] f3;
   logic [6:0] f7;
   logic [4:0] rd, rs1, rs2;
   logic       bad, use_rd, use_rs1, use_rs2;

   assign opcode = ir[6:0];
   assign f3     = ir[14:12];
   assign f7     = ir[31:25];
   assign rd     = ir[11:7];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];

   always_comb begin
      ctl     = '0;
      bad     = 1'b0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      ebreak  = 1'b0;
      case (opcode)
         OPC_LUI: begin
            ctl.ext_op    = EXT_U;
            ctl.alu_op    = ALU_COPY_B;
            ctl.alu_b_src = B_SRC_IMM;
            use_rd        = 1'b1;
         end
         OPC_AUIPC: begin
            ctl.ext_op    = EXT_U;
            ctl.alu_a_src = ALU_SRC_PC;
            ctl.alu_b_src = B_SRC_IMM;
            use_rd        = 1'b1;
         end
         OPC_JAL: begin
            ctl.ext_op    = EXT_J;
            ctl.alu_a_src = ALU_SRC_PC;
            ctl.alu_b_src = B_SRC_FOUR;
            ctl.branch    = BR_JAL;
            use_rd        = 1'b1;
         end
         OPC_JALR: begin
            ctl.ext_op    = EXT_I;
            ctl.alu_a_src = ALU_SRC_PC;
            ctl.alu_b_src = B_SRC_FOUR;
            ctl.branch    = BR_JALR;
            use_rd        = 1'b1;
            use_rs1       = 1'b1;
            bad           = (f3 != 3'b000);
         end
         OPC_BRANCH: begin
            ctl.ext_op    = EXT_B;
            ctl.alu_op    = ALU_SUB;
            ctl.alu_b_src = B_SRC_RS2;
            ctl.branch    = {BR_COND, f3};
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            bad           = (f3 == 3'b010) || (f3 == 3'b011);
         end
         OPC_LOAD: begin
            ctl.ext_op     = EXT_I;
            ctl.alu_b_src  = B_SRC_IMM;
            ctl.mem_to_reg = 1'b1;
            ctl.is_load    = 1'b1;
            ctl.lsu_op     = f3;
            use_rd         = 1'b1;
            use_rs1        = 1'b1;
            bad            = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
         end
         OPC_STORE: begin
            ctl.ext_op    = EXT_S;
            ctl.alu_b_src = B_SRC_IMM;
            ctl.is_store  = 1'b1;
            ctl.lsu_op    = f3;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            bad           = (f3[2] || f3 == 3'b011);
         end
         OPC_OP_IMM: begin
            ctl.ext_op    = EXT_I;
            ctl.alu_b_src = B_SRC_IMM;
            // for non-shift ops the upper bits are immediate, so only 101 may pick SRA
            ctl.alu_op    = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
            use_rd        = 1'b1;
            use_rs1       = 1'b1;
            if (f3 == 3'b001)
               bad = (f7 != 7'b0000000);
            else if (f3 == 3'b101)
               bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
         end
         OPC_OP: begin
            ctl.alu_b_src = B_SRC_RS2;
            ctl.alu_op    = alu_from_f3(f3, f7[5]);
            use_rd        = 1'b1;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            if (f7 == 7'b0100000)
               bad = (f3 != 3'b000) && (f3 != 3'b101);
            else
               bad = (f7 != 7'b0000000);
         end
         OPC_FENCE: begin
            bad = (f3 != 3'b000);
         end
         OPC_SYSTEM: begin
            if (ir == INST_EBREAK && EN_EBREAK)
               ebreak = 1'b1;
            else if (ir != INST_ECALL)
               bad = 1'b1;
         end
         default: bad = 1'b1;
      endcase
      ctl.rd_wr = use_rd && (rd != 5'd0);
      illegal   = bad || (RVE && ((use_rd && rd[4]) || (use_rs1 && rs1[4]) || (use_rs2 && rs2[4])));
   end

endmodule

// File: rtl/ysyx_25030081_mcu.sv
// rtl/ysyx_25030081_mcu.sv - multi-cycle control FSM sequencing fetch, decode, execute, memory, writeback
module ysyx_25030081_mcu
   import ysyx_25030081_cu_pkg::*;
#(
   parameter bit RVE       = 1'b0,
   parameter bit EN_EBREAK = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req,
   input  logic        ifu_valid,
   input  logic [31:0] inst,
   output logic        lsu_req,
   output logic        lsu_wr,
   output logic [2:0]  lsu_op,
   input  logic        lsu_done,
   output logic [2:0]  ext_op,
   output logic        alu_a_src,
   output logic [1:0]  alu_b_src,
   output logic [3:0]  alu_op,
   output logic [3:0]  branch,
   output logic        mem_to_reg,
   output logic        reg_wr,
   output logic        pc_wr,
   output logic        illegal,
   output logic        halt
);

   logic [2:0]  state;
   logic [31:0] ir;
   ctl_t        ctl_q;
   ctl_t        dec_ctl;
   logic        dec_illegal;
   logic        dec_ebreak;

   ysyx_25030081_idu_dec #(
      .RVE       (RVE),
      .EN_EBREAK (EN_EBREAK)
   ) u_dec (
      .ir      (ir),
      .ctl     (dec_ctl),
      .illegal (dec_illegal),
      .ebreak  (dec_ebreak)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
         ir    <= '0;
         ctl_q <= '0;
      end else begin
         case (state)
            S_FETCH: begin
               if (ifu_valid) begin
                  ir    <= inst;
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               ctl_q <= dec_ctl;
               if (dec_illegal)
                  state <= S_TRAP;
               else if (dec_ebreak)
                  state <= S_HALT;
               else
                  state <= S_EXEC;
            end
            S_EXEC:  state <= (ctl_q.is_load || ctl_q.is_store) ? S_MEM : S_WB;
            S_MEM: begin
               if (lsu_done)
                  state <= ctl_q.is_load ? S_WB : S_FETCH;
            end
            S_WB:    state <= S_FETCH;
            S_HALT:  state <= S_HALT;
            default: state <= S_TRAP;
         endcase
      end
   end

   // rst gates the handshakes and strobes so nothing is issued while it is held
   assign ifu_req    = !rst && (state == S_FETCH);
   assign lsu_req    = !rst && (state == S_MEM);
   assign lsu_wr     = lsu_req && ctl_q.is_store;
   assign lsu_op     = ctl_q.lsu_op;
   assign reg_wr     = !rst && (state == S_WB) && ctl_q.rd_wr;
   assign pc_wr      = !rst && ((state == S_WB) || (lsu_req && lsu_done && ctl_q.is_store));
   assign illegal    = !rst && (state == S_TRAP);
   assign halt       = !rst && (state == S_HALT);

   assign ext_op     = ctl_q.ext_op;
   assign alu_a_src  = ctl_q.alu_a_src;
   assign alu_b_src  = ctl_q.alu_b_src;
   assign alu_op     = ctl_q.alu_op;
   assign branch     = ctl_q.branch;
   assign mem_to_reg = ctl_q.mem_to_reg;

endmodule

// File: tb/tb_ysyx_25030081_mcu.sv
// tb/tb_ysyx_25030081_mcu.sv - directed self-checking bench for the multi-cycle control unit
module tb_ysyx_25030081_mcu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ifu_valid = 1'b0;
   logic [31:0] inst = '0;
   logic        lsu_done = 1'b0;

   logic        ifu_req, lsu_req, lsu_wr, mem_to_reg, reg_wr, pc_wr, illegal, halt, alu_a_src;
   logic [2:0]  lsu_op, ext_op;
   logic [1:0]  alu_b_src;
   logic [3:0]  alu_op, branch;

   logic        ifu_req_e, lsu_req_e, lsu_wr_e, mem_to_reg_e, reg_wr_e, pc_wr_e, illegal_e, halt_e, alu_a_src_e;
   logic [2:0]  lsu_op_e, ext_op_e;
   logic [1:0]  alu_b_src_e;
   logic [3:0]  alu_op_e, branch_e;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ysyx_25030081_mcu #(.RVE(1'b0), .EN_EBREAK(1'b1)) dut (
      .clk(clk), .rst(rst), .ifu_req(ifu_req), .ifu_valid(ifu_valid), .inst(inst),
      .lsu_req(lsu_req), .lsu_wr(lsu_wr), .lsu_op(lsu_op), .lsu_done(lsu_done),
      .ext_op(ext_op), .alu_a_src(alu_a_src), .alu_b_src(alu_b_src), .alu_op(alu_op),
      .branch(branch), .mem_to_reg(mem_to_reg), .reg_wr(reg_wr), .pc_wr(pc_wr),
      .illegal(illegal), .halt(halt)
   );

   // RV32E variant without ebreak support, fed the same stimulus
   ysyx_25030081_mcu #(.RVE(1'b1), .EN_EBREAK(1'b0)) dut_e (
      .clk(clk), .rst(rst), .ifu_req(ifu_req_e), .ifu_valid(ifu_valid), .inst(inst),
      .lsu_req(lsu_req_e), .lsu_wr(lsu_wr_e), .lsu_op(lsu_op_e), .lsu_done(lsu_done),
      .ext_op(ext_op_e), .alu_a_src(alu_a_src_e), .alu_b_src(alu_b_src_e), .alu_op(alu_op_e),
      .branch(branch_e), .mem_to_reg(mem_to_reg_e), .reg_wr(reg_wr_e), .pc_wr(pc_wr_e),
      .illegal(illegal_e), .halt(halt_e)
   );

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic test_reset();
      step();
      step();
      checks++; if (ifu_req !== 1'b0) begin errors++; $display("FAIL reset_ifu_req got %b exp 0", ifu_req); end
      checks++; if (lsu_req !== 1'b0) begin errors++; $display("FAIL reset_lsu_req got %b exp 0", lsu_req); end
      checks++; if ({reg_wr, pc_wr, illegal, halt} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {reg_wr, pc_wr, illegal, halt}); end
      checks++; if ({ext_op, alu_a_src, alu_b_src, alu_op, branch, mem_to_reg} !== 15'd0) begin errors++; $display("FAIL reset_ctl got %h exp 0", {ext_op, alu_a_src, alu_b_src, alu_op, branch, mem_to_reg}); end
      rst = 1'b0;
      #1;
      checks++; if (ifu_req !== 1'b1) begin errors++; $display("FAIL reset_fetch got %b exp 1", ifu_req); end
   endtask

   task automatic test_addi();
      ifu_valid = 1'b1; inst = 32'h0050_0093;
      step();
      ifu_valid = 1'b0;
      checks++; if ({ifu_req, reg_wr, pc_wr} !== 3'b000) begin errors++; $display("FAIL addi_c2 got %b exp 000", {ifu_req, reg_wr, pc_wr}); end
      step();
      checks++; if ({ext_op, alu_b_src, alu_op, alu_a_src} !== {3'd0, 2'd1, 4'd0, 1'b0}) begin errors++; $display("FAIL addi_ctl got %h exp %h", {ext_op, alu_b_src, alu_op, alu_a_src}, {3'd0, 2'd1, 4'd0, 1'b0}); end
      checks++; if ({reg_wr, pc_wr} !== 2'b00) begin errors++; $display("FAIL addi_c3_strobe got %b exp 00", {reg_wr, pc_wr}); end
      step();
      checks++; if ({reg_wr, pc_wr} !== 2'b11) begin errors++; $display("FAIL addi_wb got %b exp 11", {reg_wr, pc_wr}); end
      step();
      checks++; if ({ifu_req, reg_wr, pc_wr} !== 3'b100) begin errors++; $display("FAIL addi_c5 got %b exp 100", {ifu_req, reg_wr, pc_wr}); end
   endtask

   task automatic test_load();
      ifu_valid = 1'b1; inst = 32'h0040_A183;
      step();
      ifu_valid = 1'b0;
      step();
      checks++; if (lsu_req !== 1'b0) begin errors++; $display("FAIL load_exec_req got %b exp 0", lsu_req); end
      step();
      checks++; if ({lsu_wr, lsu_op, mem_to_reg} !== {1'b0, 3'd2, 1'b1}) begin errors++; $display("FAIL load_mem_ctl got %b exp 00101", {lsu_wr, lsu_op, mem_to_reg}); end
      for (int i = 0; i < 3; i++) begin
         checks++; if ({lsu_req, reg_wr, pc_wr} !== 3'b100) begin errors++; $display("FAIL load_wait%0d got %b exp 100", i, {lsu_req, reg_wr, pc_wr}); end
         step();
      end
      lsu_done = 1'b1;
      #1;
      checks++; if ({lsu_req, reg_wr, pc_wr} !== 3'b100) begin errors++; $display("FAIL load_done got %b exp 100", {lsu_req, reg_wr, pc_wr}); end
      step();
      lsu_done = 1'b0;
      checks++; if ({lsu_req, reg_wr, pc_wr} !== 3'b011) begin errors++; $display("FAIL load_wb got %b exp 011", {lsu_req, reg_wr, pc_wr}); end
      step();
      checks++; if (ifu_req !== 1'b1) begin errors++; $display("FAIL load_refetch got %b exp 1", ifu_req); end
   endtask

   task automatic test_store();
      lsu_done = 1'b1;
      ifu_valid = 1'b1; inst = 32'h0030_A423;
      #1;
      checks++; if (pc_wr !== 1'b0) begin errors++; $display("FAIL store_fetch_pc got %b exp 0", pc_wr); end
      step();
      ifu_valid = 1'b0;
      checks++; if ({lsu_req, pc_wr} !== 2'b00) begin errors++; $display("FAIL store_dec got %b exp 00", {lsu_req, pc_wr}); end
      step();
      checks++; if ({ext_op, lsu_req, pc_wr} !== {3'd1, 2'b00}) begin errors++; $display("FAIL store_exec got %b exp 00100", {ext_op, lsu_req, pc_wr}); end
      step();
      checks++; if ({lsu_req, lsu_wr, lsu_op, pc_wr, reg_wr} !== {2'b11, 3'd2, 2'b10}) begin errors++; $display("FAIL store_mem got %b exp 1101010", {lsu_req, lsu_wr, lsu_op, pc_wr, reg_wr}); end
      step();
      lsu_done = 1'b0;
      checks++; if ({ifu_req, reg_wr, pc_wr} !== 3'b100) begin errors++; $display("FAIL store_refetch got %b exp 100", {ifu_req, reg_wr, pc_wr}); end
   endtask

   task automatic test_back_to_back();
      ifu_valid = 1'b1; inst = 32'h1234_5137;
      step(); ifu_valid = 1'b0;
      step();
      checks++; if ({alu_op, ext_op, alu_b_src} !== {4'd10, 3'd3, 2'd1}) begin errors++; $display("FAIL lui_ctl got %h exp %h", {alu_op, ext_op, alu_b_src}, {4'd10, 3'd3, 2'd1}); end
      step();
      checks++; if (reg_wr !== 1'b1) begin errors++; $display("FAIL lui_reg_wr got %b exp 1", reg_wr); end
      step();
      ifu_valid = 1'b1; inst = 32'h0000_0463;
      step(); ifu_valid = 1'b0;
      step();
      checks++; if ({branch, ext_op, alu_op, alu_b_src} !== {4'd8, 3'd2, 4'd1, 2'd0}) begin errors++; $display("FAIL beq_ctl got %h exp %h", {branch, ext_op, alu_op, alu_b_src}, {4'd8, 3'd2, 4'd1, 2'd0}); end
      step();
      checks++; if ({reg_wr, pc_wr} !== 2'b01) begin errors++; $display("FAIL beq_wb got %b exp 01", {reg_wr, pc_wr}); end
      step();
      ifu_valid = 1'b1; inst = 32'h0002_80E7;
      step(); ifu_valid = 1'b0;
      step();
      checks++; if ({branch, alu_a_src, alu_b_src, alu_op, ext_op} !== {4'd2, 1'b1, 2'd2, 4'd0, 3'd0}) begin errors++; $display("FAIL jalr_ctl got %h exp %h", {branch, alu_a_src, alu_b_src, alu_op, ext_op}, {4'd2, 1'b1, 2'd2, 4'd0, 3'd0}); end
      step();
      checks++; if ({reg_wr, pc_wr} !== 2'b11) begin errors++; $display("FAIL jalr_wb got %b exp 11", {reg_wr, pc_wr}); end
      step();
   endtask

   task automatic test_ebreak();
      ifu_valid = 1'b1; inst = 32'h0010_0073;
      step(); ifu_valid = 1'b0;
      step();
      checks++; if ({halt, illegal, ifu_req, pc_wr} !== 4'b1000) begin errors++; $display("FAIL ebreak_halt got %b exp 1000", {halt, illegal, ifu_req, pc_wr}); end
      checks++; if ({halt_e, illegal_e} !== 2'b01) begin errors++; $display("FAIL ebreak_noen got %b exp 01", {halt_e, illegal_e}); end
      ifu_valid = 1'b1;
      step(); step();
      ifu_valid = 1'b0;
      checks++; if ({halt, ifu_req, reg_wr, pc_wr} !== 4'b1000) begin errors++; $display("FAIL ebreak_sticky got %b exp 1000", {halt, ifu_req, reg_wr, pc_wr}); end
   endtask

   task automatic test_illegal();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      ifu_valid = 1'b1; inst = 32'h0000_0A33;
      step(); ifu_valid = 1'b0;
      step();
      checks++; if ({illegal, illegal_e} !== 2'b01) begin errors++; $display("FAIL rve_add got %b exp 01", {illegal, illegal_e}); end
      step();
      checks++; if ({reg_wr, ifu_req_e} !== 2'b10) begin errors++; $display("FAIL rve_wb got %b exp 10", {reg_wr, ifu_req_e}); end
      step();
      ifu_valid = 1'b1; inst = 32'hFFFF_FFFF;
      step(); ifu_valid = 1'b0;
      step();
      checks++; if ({illegal, ifu_req, halt} !== 3'b100) begin errors++; $display("FAIL illegal_trap got %b exp 100", {illegal, ifu_req, halt}); end
      for (int i = 0; i < 3; i++) step();
      checks++; if ({illegal, ifu_req, pc_wr, reg_wr} !== 4'b1000) begin errors++; $display("FAIL illegal_sticky got %b exp 1000", {illegal, ifu_req, pc_wr, reg_wr}); end
   endtask

   task automatic test_reset_in_mem();
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++; if ({illegal, ifu_req} !== 2'b01) begin errors++; $display("FAIL rst_clears_trap got %b exp 01", {illegal, ifu_req}); end
      ifu_valid = 1'b1; inst = 32'h0040_A183;
      step(); ifu_valid = 1'b0;
      step(); step();
      checks++; if ({lsu_req, mem_to_reg} !== 2'b11) begin errors++; $display("FAIL rst_mem_entry got %b exp 11", {lsu_req, mem_to_reg}); end
      rst = 1'b1;
      step();
      checks++; if ({lsu_req, ifu_req, mem_to_reg, illegal, halt} !== 5'b00000) begin errors++; $display("FAIL rst_mem_abort got %b exp 00000", {lsu_req, ifu_req, mem_to_reg, illegal, halt}); end
      rst = 1'b0;
      #1;
      checks++; if ({ifu_req, lsu_req} !== 2'b10) begin errors++; $display("FAIL rst_mem_fetch got %b exp 10", {ifu_req, lsu_req}); end
      step();
      checks++; if ({ifu_req, lsu_req, pc_wr} !== 3'b100) begin errors++; $display("FAIL rst_mem_idle got %b exp 100", {ifu_req, lsu_req, pc_wr}); end
   endtask

   initial begin
      test_reset();
      test_addi();
      test_load();
      test_store();
      test_back_to_back();
      test_ebreak();
      test_illegal();
      test_reset_in_mem();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ysyx_25030081_mcu.md
Name: ysyx_25030081_mcu

Overview:
Multi-cycle control unit for the NPC core. It replaces the purely combinational decoder with an instruction-sequencing FSM and full RV32I/RV32E decode.
- Sequences fetch, decode, execute, memory and writeback.
- Handshakes with the IFU and LSU.
- Flags illegal instructions and halts on ebreak.
- Sits between the IFU/LSU and the datapath (regfile, ALU, immediate extender, PC).

Parameters:
RVE, 0, 1 = RV32E: any rd/rs1/rs2 index >= 16 is illegal; 0 = RV32I.
EN_EBREAK, 1, 1 = ebreak enters HALT; 0 = ebreak is illegal.

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
ifu_req  out  1  fetch request, held until ifu_valid
ifu_valid  in  1  instruction on inst is valid this cycle
inst  in  32  fetched instruction word
lsu_req  out  1  memory request, held until lsu_done
lsu_wr  out  1  1 = store, 0 = load; valid while lsu_req
lsu_op  out  3  funct3 of the load/store
lsu_done  in  1  memory access complete
ext_op  out  3  immediate type: 0 I, 1 S, 2 B, 3 U, 4 J
alu_a_src  out  1  0 = rs1, 1 = PC
alu_b_src  out  2  0 = rs2, 1 = imm, 2 = const 4
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 COPY_B
branch  out  4  0 none, 1 jal, 2 jalr, 8+funct3 for B-type
mem_to_reg  out  1  writeback source is load data
reg_wr  out  1  regfile write strobe, one cycle
pc_wr  out  1  PC update strobe, one cycle
illegal  out  1  sticky illegal-instruction flag
halt  out  1  sticky ebreak halt flag

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP.
- Reset: rst dominates any state. Next state is FETCH. All outputs and the internal IR read 0.
- FETCH: ifu_req = 1. On ifu_valid, IR <= inst and go to DECODE. ifu_valid seen outside FETCH is ignored.
- DECODE (1 cycle): decode IR and register all datapath control outputs; they are held stable until the next DECODE.
  - Unknown opcode/funct3/funct7, low two bits != 11, or RVE index violation -> TRAP.
  - ebreak with EN_EBREAK = 1 -> HALT.
  - fence and ecall are treated as nop.
- EXEC (1 cycle): load/store -> MEM; all other instructions -> WB.
- MEM: lsu_req = 1, with lsu_wr and lsu_op valid, until lsu_done. lsu_done outside MEM is ignored.
  - Load: on lsu_done go to WB.
  - Store: on lsu_done, pc_wr = 1 for that cycle, then FETCH.
- WB (1 cycle):
  - reg_wr = 1 unless the instruction is B-type or has rd = 0 (no regfile write for x0).
  - pc_wr = 1.
  - Go to FETCH.
- HALT: halt = 1. TRAP: illegal = 1. Both are terminal until rst; no requests or strobes are issued in either.
- Latency with zero-wait handshakes:
  - ALU, jump and branch instructions: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
- Decode values:
  - lui: ext 3, alu COPY_B, b_src 1.
  - auipc: a_src 1, b_src 1, ADD.
  - jal/jalr: a_src 1, b_src 2, ADD (link value); branch 1 or 2.
  - B-type: SUB, b_src 0.
  - Loads: ext 0, mem_to_reg 1, ADD, b_src 1.
  - Stores: ext 1, ADD, b_src 1.
  - OP-IMM: slli/srli/srai require imm[11:5] = 0000000 / 0000000 / 0100000, otherwise illegal.
  - OP: funct7 must be 0000000, or 0100000 for sub/sra only.

Decomposition:
- Package ysyx_25030081_cu_pkg: state enum, opcode constants, ALU_*, EXT_*, BR_* codes, plus ALU_SRC and B_SRC constants.
- Sub-module ysyx_25030081_idu_dec: purely combinational decoder, IR -> control bundle plus illegal/ebreak. The FSM registers its outputs in DECODE.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with ifu_valid on the first cycle -> one-cycle reg_wr and one-cycle pc_wr on cycle 4; ext 0, b_src 1, alu 0; next ifu_req on cycle 5.
- lw x3,4(x1) (0x0040A183) with lsu_done 3 cycles late -> lsu_req held 4 cycles; lsu_wr 0, lsu_op 2, mem_to_reg 1; reg_wr in the cycle after lsu_done.
- sw x3,8(x1) (0x0030A423) -> lsu_wr 1, ext 1, pc_wr on the lsu_done cycle, reg_wr never asserted, back to FETCH.
- lui x2,0x12345 (0x12345137) then beq x0,x0,8 (0x00000463) -> alu 10/ext 3 for the lui; branch 8, ext 2, alu 1, reg_wr 0 for the beq.
- 0xFFFFFFFF -> illegal = 1 sticky and ifu_req stays 0. With RVE = 1, add x20,x0,x0 (0x00000A33) also traps.
- ebreak (0x00100073) -> halt = 1. Assert rst during a MEM wait -> lsu_req 0 the next cycle, state FETCH, flags cleared.
